// File: rtl/mips32_exec_decode_pkg.sv
// rtl/mips32_exec_decode_pkg.sv - opcode/funct constants and decode encodings for the exec/decode slice
package mips32_exec_decode_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    typedef enum logic [2:0] {
        ALUOP_RTYPE = 3'b000,
        ALUOP_ADD   = 3'b001,
        ALUOP_SUB   = 3'b010,
        ALUOP_AND   = 3'b011,
        ALUOP_OR    = 3'b100
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_SLL  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SRC_RT   = 2'b00,
        SRC_SIMM = 2'b01,
        SRC_ZIMM = 2'b10,
        SRC_ZERO = 2'b11
    } alu_src_e;

    typedef struct packed {
        logic     reg_dest;
        logic     branch;
        logic     jump;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     reg_write;
        alu_src_e alu_src;
        alu_op_e  alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips32_exec_decode_if.sv
// rtl/mips32_exec_decode_if.sv - instruction/operand inputs and registered control/result outputs
interface mips32_exec_decode_if;
    import mips32_exec_decode_pkg::*;

    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              reg_dest;
    logic [4:0]        write_reg;
    logic              branch;
    logic              branch_taken;
    logic              jump;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [1:0]        alu_src;
    logic [2:0]        alu_op;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              zero;

    modport master (
        output instruction, rs_data, rt_data,
        input  reg_dest, write_reg, branch, branch_taken, jump, mem_read, mem_write,
               mem_to_reg, reg_write, alu_src, alu_op, alu_ctrl, alu_result, zero
    );

    modport slave (
        input  instruction, rs_data, rt_data,
        output reg_dest, write_reg, branch, branch_taken, jump, mem_read, mem_write,
               mem_to_reg, reg_write, alu_src, alu_op, alu_ctrl, alu_result, zero
    );
endinterface

// File: rtl/mips32_alu_core.sv
// rtl/mips32_alu_core.sv - combinational 32-bit ALU with zero flag
module mips32_alu_core
    import mips32_exec_decode_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_ctrl_e         i_alu_ctrl,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_alu_ctrl)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLL:  o_result = i_a << i_b[4:0];
            ALU_SRL:  o_result = i_a >> i_b[4:0];
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
            default:  o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/mips32_exec_decode.sv
// rtl/mips32_exec_decode.sv - registered main control, ALU control and ALU execute slice
module mips32_exec_decode
    import mips32_exec_decode_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    mips32_exec_decode_if.slave bus
);

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic [4:0]       w_shamt;
    logic [15:0]      w_imm;
    ctrl_t            w_ctrl;
    alu_ctrl_e        w_alu_ctrl;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_branch_taken;
    logic [4:0]       w_write_reg;

    ctrl_t            r_ctrl;
    alu_ctrl_e        r_alu_ctrl;
    logic [4:0]       r_write_reg;
    logic             r_branch_taken;
    logic [WIDTH-1:0] r_alu_result;
    logic             r_zero;

    assign w_op    = bus.instruction[31:26];
    assign w_rt    = bus.instruction[20:16];
    assign w_rd    = bus.instruction[15:11];
    assign w_shamt = bus.instruction[10:6];
    assign w_funct = bus.instruction[5:0];
    assign w_imm   = bus.instruction[15:0];

    // Unknown opcodes fall through with every control bit clear so they have no side effects
    always_comb begin
        w_ctrl        = '0;
        w_ctrl.alu_op = ALUOP_ADD;
        case (w_op)
            OP_RTYPE: begin
                w_ctrl.reg_dest  = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_RTYPE;
            end
            OP_LW: begin
                w_ctrl.alu_src    = SRC_SIMM;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = SRC_SIMM;
                w_ctrl.mem_write = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                w_ctrl.alu_src   = SRC_SIMM;
                w_ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                w_ctrl.alu_src   = SRC_ZIMM;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_AND;
            end
            OP_ORI: begin
                w_ctrl.alu_src   = SRC_ZIMM;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_OR;
            end
            OP_BEQ, OP_BNE: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
            end
            OP_J:    w_ctrl.jump = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_ctrl.alu_op)
            ALUOP_RTYPE: begin
                case (w_funct)
                    FN_ADD, FN_ADDU: w_alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: w_alu_ctrl = ALU_SUB;
                    FN_AND:          w_alu_ctrl = ALU_AND;
                    FN_OR:           w_alu_ctrl = ALU_OR;
                    FN_XOR:          w_alu_ctrl = ALU_XOR;
                    FN_SLTU:         w_alu_ctrl = ALU_SLTU;
                    FN_SLL:          w_alu_ctrl = ALU_SLL;
                    FN_SRL:          w_alu_ctrl = ALU_SRL;
                    default:         w_alu_ctrl = ALU_ADD;
                endcase
            end
            ALUOP_SUB: w_alu_ctrl = ALU_SUB;
            ALUOP_AND: w_alu_ctrl = ALU_AND;
            ALUOP_OR:  w_alu_ctrl = ALU_OR;
            default:   w_alu_ctrl = ALU_ADD;
        endcase
    end

    // Any R-type funct with bit 5 clear is treated as a shift-form operand pair (rt, shamt)
    assign w_is_shift = (w_op == OP_RTYPE) && !w_funct[5];

    always_comb begin
        w_op_a = bus.rs_data;
        w_op_b = '0;
        if (w_is_shift) begin
            w_op_a = bus.rt_data;
            w_op_b = {{(WIDTH-5){1'b0}}, w_shamt};
        end else begin
            case (w_ctrl.alu_src)
                SRC_RT:   w_op_b = bus.rt_data;
                SRC_SIMM: w_op_b = {{(WIDTH-16){w_imm[15]}}, w_imm};
                SRC_ZIMM: w_op_b = {{(WIDTH-16){1'b0}}, w_imm};
                default:  w_op_b = '0;
            endcase
        end
    end

    mips32_alu_core u_alu (
        .i_a        (w_op_a),
        .i_b        (w_op_b),
        .i_alu_ctrl (w_alu_ctrl),
        .o_result   (w_result),
        .o_zero     (w_zero)
    );

    assign w_branch_taken = ((w_op == OP_BEQ) && w_zero) || ((w_op == OP_BNE) && !w_zero);
    assign w_write_reg    = w_ctrl.reg_dest ? w_rd : w_rt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl         <= '0;
            r_alu_ctrl     <= ALU_AND;
            r_write_reg    <= '0;
            r_branch_taken <= 1'b0;
            r_alu_result   <= '0;
            r_zero         <= 1'b0;
        end else begin
            r_ctrl         <= w_ctrl;
            r_alu_ctrl     <= w_alu_ctrl;
            r_write_reg    <= w_write_reg;
            r_branch_taken <= w_branch_taken;
            r_alu_result   <= w_result;
            r_zero         <= w_zero;
        end
    end

    assign bus.reg_dest     = r_ctrl.reg_dest;
    assign bus.write_reg    = r_write_reg;
    assign bus.branch       = r_ctrl.branch;
    assign bus.branch_taken = r_branch_taken;
    assign bus.jump         = r_ctrl.jump;
    assign bus.mem_read     = r_ctrl.mem_read;
    assign bus.mem_write    = r_ctrl.mem_write;
    assign bus.mem_to_reg   = r_ctrl.mem_to_reg;
    assign bus.reg_write    = r_ctrl.reg_write;
    assign bus.alu_src      = r_ctrl.alu_src;
    assign bus.alu_op       = r_ctrl.alu_op;
    assign bus.alu_ctrl     = r_alu_ctrl;
    assign bus.alu_result   = r_alu_result;
    assign bus.zero         = r_zero;

endmodule

// File: tb/tb_mips32_exec_decode.sv
// tb/tb_mips32_exec_decode.sv - vector table, async reset sequence and random model check for mips32_exec_decode
module tb_mips32_exec_decode;

    typedef struct packed {
        logic        reg_dest;
        logic [4:0]  write_reg;
        logic        branch;
        logic        branch_taken;
        logic        jump;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [1:0]  alu_src;
        logic [2:0]  alu_op;
        logic [2:0]  alu_ctrl;
        logic [31:0] alu_result;
        logic        zero;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        obs_t        exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mips32_exec_decode_if bus ();

    mips32_exec_decode #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // flags = {reg_dest, branch, branch_taken, jump, mem_read, mem_write, mem_to_reg, reg_write}
    function automatic obs_t mk(input logic [7:0] flags, input logic [4:0] wr, input logic [1:0] src,
                                input logic [2:0] aop, input logic [2:0] actl, input logic [31:0] res,
                                input logic z);
        obs_t o;
        o.reg_dest     = flags[7];
        o.branch       = flags[6];
        o.branch_taken = flags[5];
        o.jump         = flags[4];
        o.mem_read     = flags[3];
        o.mem_write    = flags[2];
        o.mem_to_reg   = flags[1];
        o.reg_write    = flags[0];
        o.write_reg    = wr;
        o.alu_src      = src;
        o.alu_op       = aop;
        o.alu_ctrl     = actl;
        o.alu_result   = res;
        o.zero         = z;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.reg_dest     = bus.reg_dest;
        o.write_reg    = bus.write_reg;
        o.branch       = bus.branch;
        o.branch_taken = bus.branch_taken;
        o.jump         = bus.jump;
        o.mem_read     = bus.mem_read;
        o.mem_write    = bus.mem_write;
        o.mem_to_reg   = bus.mem_to_reg;
        o.reg_write    = bus.reg_write;
        o.alu_src      = bus.alu_src;
        o.alu_op       = bus.alu_op;
        o.alu_ctrl     = bus.alu_ctrl;
        o.alu_result   = bus.alu_result;
        o.zero         = bus.zero;
        return o;
    endfunction

    // Reference model: plain per-instruction semantics, numeric codes taken straight from the ISA tables
    function automatic obs_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        obs_t        o;
        logic [5:0]  op    = ins[31:26];
        logic [5:0]  fn    = ins[5:0];
        logic [31:0] simm  = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] zimm  = {16'h0, ins[15:0]};
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        o = '0;
        o.alu_op = 3'd1;
        if (op == 6'h00) begin
            o.reg_dest = 1; o.reg_write = 1; o.alu_op = 3'd0;
        end else if (op == 6'h23) begin
            o.alu_src = 2'd1; o.mem_read = 1; o.mem_to_reg = 1; o.reg_write = 1;
        end else if (op == 6'h2B) begin
            o.alu_src = 2'd1; o.mem_write = 1;
        end else if (op == 6'h08 || op == 6'h09) begin
            o.alu_src = 2'd1; o.reg_write = 1;
        end else if (op == 6'h0C) begin
            o.alu_src = 2'd2; o.reg_write = 1; o.alu_op = 3'd3;
        end else if (op == 6'h0D) begin
            o.alu_src = 2'd2; o.reg_write = 1; o.alu_op = 3'd4;
        end else if (op == 6'h04 || op == 6'h05) begin
            o.branch = 1; o.alu_op = 3'd2;
        end else if (op == 6'h02) begin
            o.jump = 1;
        end
        if (o.alu_op == 3'd2)      o.alu_ctrl = 3'd6;
        else if (o.alu_op == 3'd3) o.alu_ctrl = 3'd0;
        else if (o.alu_op == 3'd4) o.alu_ctrl = 3'd1;
        else if (o.alu_op == 3'd0) begin
            if (fn == 6'h20 || fn == 6'h21)      o.alu_ctrl = 3'd2;
            else if (fn == 6'h22 || fn == 6'h23) o.alu_ctrl = 3'd6;
            else if (fn == 6'h24)                o.alu_ctrl = 3'd0;
            else if (fn == 6'h25)                o.alu_ctrl = 3'd1;
            else if (fn == 6'h26)                o.alu_ctrl = 3'd3;
            else if (fn == 6'h2B)                o.alu_ctrl = 3'd7;
            else if (fn == 6'h00)                o.alu_ctrl = 3'd4;
            else if (fn == 6'h02)                o.alu_ctrl = 3'd5;
            else                                 o.alu_ctrl = 3'd2;
        end else o.alu_ctrl = 3'd2;
        if (op == 6'h00 && fn < 6'd32) begin
            a = rt;
            b = 32'(ins[10:6]);
        end else begin
            a = rs;
            b = (o.alu_src == 2'd1) ? simm : (o.alu_src == 2'd2) ? zimm : rt;
        end
        case (o.alu_ctrl)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = a << (b % 32);
            3'd5: r = a >> (b % 32);
            3'd6: r = a - b;
            3'd7: r = (a < b) ? 32'd1 : 32'd0;
            default: r = a + b;
        endcase
        o.alu_result   = r;
        o.zero         = (r == 0);
        o.branch_taken = (op == 6'h04 && r == 0) || (op == 6'h05 && r != 0);
        o.write_reg    = o.reg_dest ? ins[15:11] : ins[20:16];
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clock);
        bus.instruction = ins;
        bus.rs_data     = rs;
        bus.rt_data     = rt;
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[16];
    logic [5:0] ops[11] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h02, 6'h3F};
    logic [5:0] fns[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2B, 6'h00, 6'h02, 6'h08};

    initial begin
        vecs[0]  = '{"add",      32'h00221820, 32'd5,        32'd7,        mk(8'b1000_0001, 5'd3, 2'd0, 3'd0, 3'd2, 32'd12, 1'b0)};
        vecs[1]  = '{"sll",      32'h00021080, 32'h0000DEAD, 32'd3,        mk(8'b1000_0001, 5'd2, 2'd0, 3'd0, 3'd4, 32'd12, 1'b0)};
        vecs[2]  = '{"sltu_lt",  32'h0022182B, 32'd1,        32'hFFFFFFFF, mk(8'b1000_0001, 5'd3, 2'd0, 3'd0, 3'd7, 32'd1, 1'b0)};
        vecs[3]  = '{"sltu_ge",  32'h0022182B, 32'hFFFFFFFF, 32'd1,        mk(8'b1000_0001, 5'd3, 2'd0, 3'd0, 3'd7, 32'd0, 1'b1)};
        vecs[4]  = '{"lw",       32'h8C220004, 32'h100,      32'h55,       mk(8'b0000_1011, 5'd2, 2'd1, 3'd1, 3'd2, 32'h104, 1'b0)};
        vecs[5]  = '{"andi",     32'h3022FFFF, 32'h12345678, 32'h0,        mk(8'b0000_0001, 5'd2, 2'd2, 3'd3, 3'd0, 32'h5678, 1'b0)};
        vecs[6]  = '{"beq_take", 32'h10220003, 32'd9,        32'd9,        mk(8'b0110_0000, 5'd2, 2'd0, 3'd2, 3'd6, 32'd0, 1'b1)};
        vecs[7]  = '{"beq_not",  32'h10220003, 32'd9,        32'd8,        mk(8'b0100_0000, 5'd2, 2'd0, 3'd2, 3'd6, 32'd1, 1'b0)};
        vecs[8]  = '{"bne_take", 32'h14220003, 32'd9,        32'd8,        mk(8'b0110_0000, 5'd2, 2'd0, 3'd2, 3'd6, 32'd1, 1'b0)};
        vecs[9]  = '{"bne_not",  32'h14220003, 32'd9,        32'd9,        mk(8'b0100_0000, 5'd2, 2'd0, 3'd2, 3'd6, 32'd0, 1'b1)};
        vecs[10] = '{"illegal",  32'hFC000000, 32'h10,       32'h20,       mk(8'b0000_0000, 5'd0, 2'd0, 3'd1, 3'd2, 32'h30, 1'b0)};
        vecs[11] = '{"jump",     32'h08000010, 32'd3,        32'd4,        mk(8'b0001_0000, 5'd0, 2'd0, 3'd1, 3'd2, 32'd7, 1'b0)};
        vecs[12] = '{"sw_neg",   32'hAC22FFFC, 32'h100,      32'h77,       mk(8'b0000_0100, 5'd2, 2'd1, 3'd1, 3'd2, 32'hFC, 1'b0)};
        vecs[13] = '{"ori",      32'h3422F0F0, 32'h0000000F, 32'h0,        mk(8'b0000_0001, 5'd2, 2'd2, 3'd4, 3'd1, 32'hF0FF, 1'b0)};
        vecs[14] = '{"sub_wrap", 32'h00221822, 32'd0,        32'd1,        mk(8'b1000_0001, 5'd3, 2'd0, 3'd0, 3'd6, 32'hFFFFFFFF, 1'b0)};
        vecs[15] = '{"srl",      32'h00021102, 32'h1,        32'h80000000, mk(8'b1000_0001, 5'd2, 2'd0, 3'd0, 3'd5, 32'h08000000, 1'b0)};

        bus.instruction = 32'h00221820;
        bus.rs_data     = 32'd5;
        bus.rt_data     = 32'd7;
        #1;
        check("reset_initial", sample(), '0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_clocked", sample(), '0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].instr, vecs[i].rs, vecs[i].rt);
            check(vecs[i].name, sample(), vecs[i].exp);
        end

        apply(32'h00221820, 32'hFFFFFFFF, 32'd1);
        check("add_wrap", sample(), mk(8'b1000_0001, 5'd3, 2'd0, 3'd0, 3'd2, 32'd0, 1'b1));

        apply(32'h00221820, 32'd5, 32'd7);
        check("add_before_reset", sample(), vecs[0].exp);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", sample(), '0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("reset_release_hold", sample(), '0);
        @(posedge clock);
        #1;
        check("reload_after_reset", sample(), vecs[0].exp);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            logic [31:0] ins;
            logic [31:0] rs;
            logic [31:0] rt;
            r   = $urandom;
            ins = {ops[$urandom_range(0, 10)], r[25:6], fns[$urandom_range(0, 10)]};
            if (ins[31:26] == 6'h3F) ins[31:26] = 6'($urandom);
            rs  = $urandom;
            rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            apply(ins, rs, rt);
            check($sformatf("rand%0d_%h", n, ins), sample(), model(ins, rs, rt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
